// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
//
// Instruction-memory request/response bus between the fetch stage (master)
// and a variable-latency instruction memory (slave).
//
// Handshake: the master raises imem_req with imem_addr and keeps both stable
// until the slave answers with a single-cycle imem_ack carrying imem_rdata.
// The slave returns at most one ack per request, and never in the first cycle
// a request is asserted. The transfer completes on the rising edge where
// imem_req and imem_ack are both high.
//
// Signals:
//   imem_req    master -> slave  request valid
//   imem_addr   master -> slave  word address [31:2]
//   imem_ack    slave  -> master response valid
//   imem_rdata  slave  -> master instruction word
// ---------------------------------------------------------------------------
interface if_fetch_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage. Owns the PC, fetches word-aligned instructions
// from a variable-latency memory, parks a returned instruction while decode
// is stalled, and feeds decode through the IF/ID register
// (id_data = {PC+1, instr}). Redirects on decode jumps and on commit-stage
// misprediction corrections; a wrong-path request still in flight is drained
// and its response thrown away.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem            instruction-memory bus (master side)
//   stall           freeze IF/ID and the PC
//   flush           clear id_valid at the next edge
//   jpc_avail, npc  decode redirect (only taken when id_valid & ~stall)
//   correct_valid,
//   correct_pc      commit-stage correction, highest priority
//   id_data         {PCP1[31:2], instr[31:0]} to decode
//   id_valid        id_data holds a real instruction
//   state_dbg       current fetch FSM state (debug observation)
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  imem,
    input  logic        stall,
    input  logic        flush,
    input  logic        jpc_avail,
    input  logic [29:0] npc,
    input  logic        correct_valid,
    input  logic [29:0] correct_pc,
    output logic [61:0] id_data,
    output logic        id_valid,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request outstanding at pc
        S_HOLD  = 2'd1,  // instruction parked in hold_buf, no request
        S_DRAIN = 2'd2   // wrong-path request outstanding at drain_addr
    } state_t;

    state_t      state, state_nx;
    logic [29:0] pc, pc_nx;
    logic [29:0] pc_inc;
    logic [29:0] drain_addr, drain_addr_nx;
    logic [31:0] hold_buf, hold_buf_nx;
    logic [61:0] id_data_nx;
    logic        id_valid_nx;

    logic        jmp_take;
    logic        redirect;
    logic [29:0] redirect_pc;

    // A decode jump is only real when decode actually holds an instruction
    // and is not stalled; a correction is unconditional and wins.
    assign jmp_take    = jpc_avail & id_valid & ~stall;
    assign redirect    = correct_valid | jmp_take;
    assign redirect_pc = correct_valid ? correct_pc : npc;

    // Modulo 2^30: the top word wraps to 0 silently.
    assign pc_inc = pc + 30'd1;

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        drain_addr_nx = drain_addr;
        hold_buf_nx   = hold_buf;
        id_data_nx    = id_data;
        // Without a load, a stalled IF/ID keeps its content; otherwise decode
        // has consumed it and a bubble follows.
        id_valid_nx   = stall ? id_valid : 1'b0;

        unique case (state)
            S_REQ: begin
                if (redirect) begin
                    pc_nx       = redirect_pc;
                    id_valid_nx = 1'b0;
                    // Data arriving this cycle is simply dropped; otherwise
                    // the old request must still be completed and ignored.
                    if (!imem.imem_ack) begin
                        state_nx      = S_DRAIN;
                        drain_addr_nx = pc;
                    end
                end else if (imem.imem_ack) begin
                    if (stall) begin
                        hold_buf_nx = imem.imem_rdata;
                        state_nx    = S_HOLD;
                    end else begin
                        id_data_nx  = {pc_inc, imem.imem_rdata};
                        id_valid_nx = 1'b1;
                        pc_nx       = pc_inc;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_nx       = redirect_pc;
                    id_valid_nx = 1'b0;
                    state_nx    = S_REQ;
                end else if (!stall) begin
                    // pc still addresses the parked instruction.
                    id_data_nx  = {pc_inc, hold_buf};
                    id_valid_nx = 1'b1;
                    pc_nx       = pc_inc;
                    state_nx    = S_REQ;
                end
            end

            S_DRAIN: begin
                if (redirect) begin
                    pc_nx       = redirect_pc;
                    id_valid_nx = 1'b0;
                end
                // Only the one outstanding response is discarded.
                if (imem.imem_ack) begin
                    state_nx = S_REQ;
                end
            end

            default: begin
                state_nx = S_REQ;
            end
        endcase

        // The controller's squash overrides any load into IF/ID.
        if (flush) begin
            id_valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drain_addr <= 30'd0;
            hold_buf   <= 32'd0;
            id_data    <= 62'd0;
            id_valid   <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            drain_addr <= drain_addr_nx;
            hold_buf   <= hold_buf_nx;
            id_data    <= id_data_nx;
            id_valid   <= id_valid_nx;
        end
    end

    // The request is held off while reset is asserted so that no fetch is
    // issued in the reset cycle itself; it comes up the cycle rst drops.
    assign imem.imem_req  = ~rst & ((state == S_REQ) | (state == S_DRAIN));
    assign imem.imem_addr = (state == S_DRAIN) ? drain_addr : pc;
    assign state_dbg      = state;

endmodule
